// File: rtl/usb_line_pkg.sv
// Shared USB line-state definitions: command encodings, line levels and driver FSM states.
// KDRV is present only when USB_RESUME_EN is defined.
package usb_line_pkg;

  typedef enum logic [1:0] {
    CMD_BUS_RESET = 2'b00,
    CMD_KEEPALIVE = 2'b01,
    CMD_RESUME    = 2'b10,
    CMD_NOP       = 2'b11
  } cmd_e;

  localparam logic [1:0] SE0  = 2'b00;
  localparam logic [1:0] FS_J = 2'b10;
  localparam logic [1:0] LS_J = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SE0,
    ST_JDRV,
    ST_NOP
`ifdef USB_RESUME_EN
    , ST_KDRV
`endif
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [1:0] j_level(input logic low_speed);
    return low_speed ? LS_J : FS_J;
  endfunction

endpackage

// File: rtl/usb_downstream_line_driver_if.sv
// Command channel from the port controller to the downstream line driver.
interface usb_downstream_line_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic       low_speed;

  modport master (output cmd_valid, output cmd, output low_speed, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, input low_speed, output cmd_ready);
endinterface

// File: rtl/usb_seg_timer.sv
// Loadable down-counter timing one line segment; expire is high while the count is 1.
module usb_seg_timer #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expire
);
  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign expire = (count == WIDTH'(1));
endmodule

// File: rtl/usb_downstream_line_driver.sv
// Drives bus-reset, keep-alive EOP and (with USB_RESUME_EN) resume sequences on D+/D-.
module usb_downstream_line_driver
  import usb_line_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 20,
  parameter int unsigned BIT_CYCLES    = 4,
  parameter int unsigned RESUME_CYCLES = 40
) (
  input  logic                          clock,
  input  logic                          reset,
  usb_downstream_line_driver_if.slave   cmd_if,
  output logic [1:0]                    usb_out,
  output logic                          usb_oe,
  output logic                          done
);
  localparam int unsigned CW = $clog2(max3(RESET_CYCLES, RESUME_CYCLES, 2 * BIT_CYCLES) + 1);

  state_e          state, next_state;
  logic            ls_q, ls_eff, accept;
  logic            tmr_load, tmr_expire;
  logic [CW-1:0]   tmr_value;
  logic [1:0]      out_next;
  logic            oe_next;

  usb_seg_timer #(.WIDTH(CW)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .expire     (tmr_expire)
  );

  assign cmd_if.cmd_ready = (state == ST_IDLE);

  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    accept     = (state == ST_IDLE) && cmd_if.cmd_valid;
    ls_eff     = accept ? cmd_if.low_speed : ls_q;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          unique case (cmd_e'(cmd_if.cmd))
            CMD_BUS_RESET: begin
              next_state = ST_SE0;
              tmr_load   = 1'b1;
              tmr_value  = CW'(RESET_CYCLES);
            end
            CMD_KEEPALIVE: begin
              next_state = ST_SE0;
              tmr_load   = 1'b1;
              tmr_value  = CW'(2 * BIT_CYCLES);
            end
`ifdef USB_RESUME_EN
            CMD_RESUME: begin
              next_state = ST_KDRV;
              tmr_load   = 1'b1;
              tmr_value  = CW'(RESUME_CYCLES);
            end
`else
            CMD_RESUME: next_state = ST_NOP;
`endif
            default: next_state = ST_NOP;
          endcase
        end
      end
`ifdef USB_RESUME_EN
      ST_KDRV: begin
        if (tmr_expire) begin
          next_state = ST_SE0;
          tmr_load   = 1'b1;
          tmr_value  = CW'(2 * BIT_CYCLES);
        end
      end
`endif
      ST_SE0: begin
        if (tmr_expire) begin
          next_state = ST_JDRV;
          tmr_load   = 1'b1;
          tmr_value  = CW'(BIT_CYCLES);
        end
      end
      ST_JDRV: if (tmr_expire) next_state = ST_IDLE;
      ST_NOP:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Line outputs are registered from the next state so they change on the same edge as state.
  always_comb begin
    oe_next  = 1'b0;
    out_next = SE0;
    unique case (next_state)
      ST_SE0:  oe_next = 1'b1;
      ST_JDRV: begin
        oe_next  = 1'b1;
        out_next = j_level(ls_eff);
      end
`ifdef USB_RESUME_EN
      ST_KDRV: begin
        oe_next  = 1'b1;
        out_next = ~j_level(ls_eff);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      ls_q    <= 1'b0;
      usb_oe  <= 1'b0;
      usb_out <= SE0;
      done    <= 1'b0;
    end else begin
      state   <= next_state;
      ls_q    <= ls_eff;
      usb_oe  <= oe_next;
      usb_out <= out_next;
      done    <= (state != ST_IDLE) && (next_state == ST_IDLE);
    end
  end
endmodule

// File: tb/tb_usb_downstream_line_driver.sv
// Self-checking bench for usb_downstream_line_driver; honours USB_RESUME_EN like the design.
module tb_usb_downstream_line_driver;
  localparam int unsigned R   = 20;
  localparam int unsigned B   = 4;
  localparam int unsigned RES = 40;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] usb_out;
  logic       usb_oe, done;
  int         checks = 0;
  int         failures = 0;
  logic [2:0] exp_q[$];

  always #5 clock = ~clock;

  usb_downstream_line_driver_if cif ();

  usb_downstream_line_driver #(
    .RESET_CYCLES  (R),
    .BIT_CYCLES    (B),
    .RESUME_CYCLES (RES)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .cmd_if  (cif),
    .usb_out (usb_out),
    .usb_oe  (usb_oe),
    .done    (done)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_seg(input logic oe, input logic [1:0] val, input int unsigned len);
    for (int unsigned i = 0; i < len; i++) exp_q.push_back({oe, val});
  endtask

  // Expected per-cycle {oe, line} from acceptance to just before the done cycle.
  task automatic build(input logic [1:0] c, input logic ls);
    logic [1:0] j;
    j = ls ? 2'b01 : 2'b10;
    exp_q.delete();
    case (c)
      2'b00: begin push_seg(1'b1, 2'b00, R); push_seg(1'b1, j, B); end
      2'b01: begin push_seg(1'b1, 2'b00, 2 * B); push_seg(1'b1, j, B); end
`ifdef USB_RESUME_EN
      2'b10: begin push_seg(1'b1, ~j, RES); push_seg(1'b1, 2'b00, 2 * B); push_seg(1'b1, j, B); end
`else
      2'b10: push_seg(1'b0, 2'b00, 1);
`endif
      default: push_seg(1'b0, 2'b00, 1);
    endcase
  endtask

  // Entered at a negedge with the DUT idle; returns at the negedge of the done cycle.
  task automatic run_cmd(input logic [1:0] c, input logic ls);
    int unsigned n;
    build(c, ls);
    check("ready_before", cif.cmd_ready, 1'b1);
    cif.cmd_valid = 1'b1;
    cif.cmd       = c;
    cif.low_speed = ls;
    @(posedge clock);
    n = exp_q.size();
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge clock);
      if (k == 0) begin
        cif.cmd_valid = 1'b0;
        cif.cmd       = 2'($urandom);
        cif.low_speed = 1'($urandom);
      end
      check("seq_oe",    usb_oe,        exp_q[k][2]);
      check("seq_out",   usb_out,       exp_q[k][1:0]);
      check("seq_ready", cif.cmd_ready, 1'b0);
      check("seq_done",  done,          1'b0);
    end
    @(negedge clock);
    check("done_pulse", done,          1'b1);
    check("done_oe",    usb_oe,        1'b0);
    check("done_out",   usb_out,       2'b00);
    check("done_ready", cif.cmd_ready, 1'b1);
  endtask

  task automatic idle_check();
    @(negedge clock);
    check("idle_done", done,   1'b0);
    check("idle_oe",   usb_oe, 1'b0);
    check("idle_out",  usb_out, 2'b00);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] c;
    logic       ls;
    reset         = 1'b1;
    cif.cmd_valid = 1'b0;
    cif.cmd       = 2'b11;
    cif.low_speed = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_oe",    usb_oe,        1'b0);
    check("rst_out",   usb_out,       2'b00);
    check("rst_ready", cif.cmd_ready, 1'b1);
    check("rst_done",  done,          1'b0);
    reset = 1'b0;
    idle_check();

    run_cmd(2'b00, 1'b0); idle_check();
    run_cmd(2'b01, 1'b1); idle_check();
    run_cmd(2'b10, 1'b0); idle_check();
    run_cmd(2'b11, 1'b1); idle_check();
    // Back-to-back: second command accepted in the done cycle
    run_cmd(2'b01, 1'b0);
    run_cmd(2'b00, 1'b1);
    idle_check();

    // Asynchronous reset partway through a bus reset
    cif.cmd_valid = 1'b1;
    cif.cmd       = 2'b00;
    @(posedge clock);
    @(negedge clock);
    cif.cmd_valid = 1'b0;
    check("pre_rst_oe", usb_oe, 1'b1);
    repeat (9) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_oe",    usb_oe,        1'b0);
    check("async_out",   usb_out,       2'b00);
    check("async_ready", cif.cmd_ready, 1'b1);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      check("post_rst_done",  done,          1'b0);
      check("post_rst_oe",    usb_oe,        1'b0);
      check("post_rst_ready", cif.cmd_ready, 1'b1);
    end

    for (int i = 0; i < 16; i++) begin
      c  = 2'($urandom_range(0, 3));
      ls = 1'($urandom_range(0, 1));
      run_cmd(c, ls);
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    idle_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
